keypad_hex_entry: RTL and testbench
===================================

# keypad_hex_entry

Parametrised keypad-to-display entry engine: scans a ROWS×COLS active-low matrix keypad, synchronises and debounces the row returns, and rejects ghost and multi-key presses. Each accepted key is mapped to a hex digit and shifted into a DIGITS-deep entry buffer, which is time-multiplexed onto a common seven-segment bus. It is the generalised successor of the fixed 4×4, two-digit keypad/display datapath and sits directly between the FPGA pins and the keypad/display hardware.

## Interface
- ROWS, 4, keypad row count (2–8)
- COLS, 4, keypad column count (2–8)
- DIGITS, 2, display digits / entry buffer depth (1–8)
- SCAN_DIV, 2400, clk cycles each column is driven before rows are sampled
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required for press and for release
- REFRESH_DIV, 24000, clk cycles each digit is enabled
- KEYMAP, 64'hDF0E_C987_B654_A321, hex label for key index i = row*COLS+col at KEYMAP[4i+3:4i]; width 4*ROWS*COLS
- clk  input  1  system clock; the only clock
- nrst  input  1  reset, asynchronous, active-low
- row_d  input  ROWS  raw row returns, active-low, externally pulled up, asynchronous
- col_q  output  COLS  column drive, one-hot active-low
- key_valid  output  1  one-cycle pulse per accepted key
- key_code  output  4  hex label of the last accepted key; held between pulses
- digit_en  output  DIGITS  digit enables, one-hot active-high
- seg  output  7  segments {g..a}, active-low

## Operation
- Every row_d bit passes through its own two-flop synchroniser; all logic below uses the synchronised rows (rs).
- Scan FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: drive column c low; after SCAN_DIV cycles, sample rs. If exactly one row r is low, latch (r,c), clear the counter and go to DEBOUNCE. Otherwise advance c (wrapping COLS-1 to 0) and restart the dwell.
- DEBOUNCE: column c stays driven. If rs equals the latched pattern, increment the counter. Any other pattern (bounce, release, or a second row low) returns to SCAN on the same column with the dwell restarted. When the counter reaches DEBOUNCE_CYCLES-1, go to HELD.
- Entering HELD: pulse key_valid; set key_code = KEYMAP[row*COLS+col]; shift the entry buffer (digit k ← digit k-1, digit 0 ← code); set digit 0 filled.
- HELD: column c stays driven and rs is ignored except for the all-high check. While the key is held no other key can be accepted and no auto-repeat occurs. When rs is all-high, clear the counter and go to RELEASE.
- RELEASE: any low row clears the counter and the FSM stays in RELEASE. After DEBOUNCE_CYCLES consecutive all-high cycles, go to SCAN on column (c+1) mod COLS.
- A key reading two or more rows low in one column is a ghost/multi-press and is never accepted.
- Display: a refresh counter advances the digit index d every REFRESH_DIV cycles, wrapping DIGITS-1 to 0. digit_en = 1<<d. Digit 0 is rightmost and most recent.
- seg shows the standard hex 0–F glyphs of digit d, active-low. An unfilled digit drives seg = 7'h7F (blank) while still taking its enable slot.

## Timing
- Reset (nrst low, asynchronous): FSM = SCAN, c = 0, col_q = ~1 (column 0 low), counters = 0, key_valid = 0, key_code = 0, buffer = 0, all digits unfilled, d = 0, digit_en = 1, seg = 7'h7F.
- Reset asserted mid-press or mid-release aborts the sequence. The next accept requires a full debounce after nrst rises.
- Pin-to-rs latency: 2 cycles.
- A clean press is accepted no earlier than 2 + SCAN_DIV + DEBOUNCE_CYCLES cycles after its row falls while its column is driven.
- key_valid, key_code, and the buffer shift update on the same clock edge. seg reflects the new digit 0 from the next cycle that d = 0.
- col_q changes only on dwell expiry or on RELEASE→SCAN. It never glitches and always has exactly one bit low.
- The refresh counter is independent of the scan FSM and never stalls.
- Buffer full: on every accept, the oldest digit (DIGITS-1) is discarded.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8, REFRESH_DIV=4, defaults otherwise.
- Reset, no keys: col_q cycles 1110→1101→1011→0111→1110 every 4 cycles; digit_en alternates 01/10 every 4 cycles; seg = 7'h7F throughout.
- Press row 1 / col 2 cleanly for 40 cycles, then release: exactly one key_valid, key_code = 4'h6; the digit-0 slot shows 6 (seg = 7'b0000010); digit 1 stays blank; scanning resumes at col 3 after 8 high cycles.
- Same press with bounce of 3-cycle glitches during the first 10 cycles: no key_valid until 8 consecutive stable cycles, then exactly one key_valid.
- Rows 0 and 2 both low on col 0: no key_valid ever; col_q keeps scanning.
- Enter 1, 2, 3 with DIGITS=2: after the third accept, digit 1 = 2 and digit 0 = 3; 1 is discarded.
- Hold key 5, then add key 9 while 5 is held, release 9, keep 5 held: still a single key_valid with code 4'h5; no accept for 9 until 5 is released and debounced.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// Matrix keypad scanner with synchronised, debounced single-key acceptance feeding a
// shift-in hex entry buffer that is multiplexed onto a common seven-segment bus.
module keypad_hex_entry #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DIGITS          = 2,
  parameter int SCAN_DIV        = 2400,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REFRESH_DIV     = 24000,
  parameter logic [4*ROWS*COLS-1:0] KEYMAP = 64'hDF0E_C987_B654_A321
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ROWS-1:0]   row_d,
  output logic [COLS-1:0]   col_q,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic [DIGITS-1:0] digit_en,
  output logic [6:0]        seg
);

  localparam int KEYS    = ROWS * COLS;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int KEY_W   = $clog2(KEYS);
  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(REFRESH_DIV + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  rs;

  scan_state_t      state;
  scan_state_t      state_next;
  logic [COL_W-1:0] col_idx;
  logic [COL_W-1:0] col_next;
  logic [COL_W-1:0] col_inc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [ROW_W-1:0] row_lat;
  logic [ROW_W-1:0] row_lat_next;
  logic             accept;

  logic             one_low;
  logic             low_seen;
  logic             low_multi;
  logic [ROW_W-1:0] low_row;
  logic [ROWS-1:0]  held_pattern;

  logic [3:0]       key_table [KEYS];
  logic [KEY_W-1:0] key_idx;

  logic [3:0]        buffer [DIGITS];
  logic [DIGITS-1:0] filled;

  logic [REF_W-1:0] ref_cnt;
  logic [REF_W-1:0] ref_next;
  logic [DIG_W-1:0] digit_idx;
  logic [DIG_W-1:0] d_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'h40;
      4'h1:    hex_glyph = 7'h79;
      4'h2:    hex_glyph = 7'h24;
      4'h3:    hex_glyph = 7'h30;
      4'h4:    hex_glyph = 7'h19;
      4'h5:    hex_glyph = 7'h12;
      4'h6:    hex_glyph = 7'h02;
      4'h7:    hex_glyph = 7'h78;
      4'h8:    hex_glyph = 7'h00;
      4'h9:    hex_glyph = 7'h10;
      4'hA:    hex_glyph = 7'h08;
      4'hB:    hex_glyph = 7'h03;
      4'hC:    hex_glyph = 7'h46;
      4'hD:    hex_glyph = 7'h21;
      4'hE:    hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  for (genvar g = 0; g < KEYS; g++) begin : g_keymap
    assign key_table[g] = KEYMAP[4*g+3 : 4*g];
  end

  // Idle rows are pulled up, so the synchroniser resets to all-high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_meta <= '1;
      rs       <= '1;
    end else begin
      row_meta <= row_d;
      rs       <= row_meta;
    end
  end

  always_comb begin
    low_seen  = 1'b0;
    low_multi = 1'b0;
    low_row   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rs[i]) begin
        if (low_seen) low_multi = 1'b1;
        low_seen = 1'b1;
        low_row  = ROW_W'(i);
      end
    end
    one_low = low_seen && !low_multi;
  end

  assign held_pattern = ~(ROWS'(1) << row_lat);
  assign col_inc      = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  assign key_idx      = KEY_W'(row_lat) * KEY_W'(COLS) + KEY_W'(col_idx);

  always_comb begin
    state_next   = state;
    col_next     = col_idx;
    cnt_next     = cnt;
    row_lat_next = row_lat;
    accept       = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_next = '0;
          if (one_low) begin
            row_lat_next = low_row;
            state_next   = DEBOUNCE;
          end else begin
            col_next = col_inc;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != held_pattern) begin
          state_next = SCAN;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (&rs) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        if (!(&rs)) begin
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = SCAN;
          cnt_next   = '0;
          col_next   = col_inc;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = SCAN;
        cnt_next   = '0;
      end
    endcase
  end

  // col_q is registered from the next column index so the pins never see decoder glitches.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= SCAN;
      col_idx <= '0;
      cnt     <= '0;
      row_lat <= '0;
      col_q   <= ~(COLS'(1));
    end else begin
      state   <= state_next;
      col_idx <= col_next;
      cnt     <= cnt_next;
      row_lat <= row_lat_next;
      col_q   <= ~(COLS'(1) << col_next);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      filled    <= '0;
      for (int k = 0; k < DIGITS; k++) buffer[k] <= 4'h0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= key_table[key_idx];
        for (int k = DIGITS - 1; k > 0; k--) begin
          buffer[k] <= buffer[k-1];
          filled[k] <= filled[k-1];
        end
        buffer[0] <= key_table[key_idx];
        filled[0] <= 1'b1;
      end
    end
  end

  always_comb begin
    ref_next = ref_cnt + 1'b1;
    d_next   = digit_idx;
    if (ref_cnt == REF_LAST) begin
      ref_next = '0;
      d_next   = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  // Enable and segments are registered together so they always refer to the same digit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
      digit_en  <= DIGITS'(1);
      seg       <= 7'h7F;
    end else begin
      ref_cnt   <= ref_next;
      digit_idx <= d_next;
      digit_en  <= DIGITS'(1) << d_next;
      seg       <= filled[d_next] ? hex_glyph(buffer[d_next]) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Testbench for keypad_hex_entry: models the key matrix, predicts accepted codes and
// display contents from key labels, and checks the scan/display timing.
module tb_keypad_hex_entry;

  localparam int ROWS        = 4;
  localparam int COLS        = 4;
  localparam int DIGITS      = 2;
  localparam int SCAN_DIV    = 4;
  localparam int DEB         = 8;
  localparam int REFRESH_DIV = 4;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [ROWS-1:0]   row_d;
  logic [COLS-1:0]   col_q;
  logic              key_valid;
  logic [3:0]        key_code;
  logic [DIGITS-1:0] digit_en;
  logic [6:0]        seg;

  bit pressed [ROWS][COLS];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int valid_count  = 0;
  int last_valid_cyc = 0;
  logic [3:0] last_valid_code = 4'h0;

  logic [3:0] label [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] exp_entries [$];

  always #5 clk = ~clk;

  keypad_hex_entry #(
    .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB), .REFRESH_DIV(REFRESH_DIV),
    .KEYMAP(64'hDF0E_C987_B654_A321)
  ) dut (
    .clk(clk), .nrst(nrst), .row_d(row_d), .col_q(col_q), .key_valid(key_valid),
    .key_code(key_code), .digit_en(digit_en), .seg(seg)
  );

  // Passive matrix: a row reads low when any pressed key on it sits in a driven column.
  always_comb begin
    row_d = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && !col_q[c]) row_d[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nrst === 1'b1 && key_valid === 1'b1) begin
      valid_count     <= valid_count + 1;
      last_valid_cyc  <= cyc;
      last_valid_code <= key_code;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [6:0] exp_slot(input int k);
    if (k < exp_entries.size()) return glyph(exp_entries[exp_entries.size() - 1 - k]);
    return 7'h7F;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic key_down(input int r, input int c);
    pressed[r][c] = 1'b1;
  endtask

  task automatic key_up(input int r, input int c);
    pressed[r][c] = 1'b0;
  endtask

  task automatic model_accept(input int r, input int c);
    exp_entries.push_back(label[r*COLS + c]);
    if (exp_entries.size() > DIGITS) void'(exp_entries.pop_front());
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pressed[r][c] = 1'b0;
    step(2);
    nrst = 1'b1;
    exp_entries.delete();
  endtask

  task automatic sample_display(output logic [DIGITS*7-1:0] shown);
    shown = 'x;
    for (int n = 0; n < 2*REFRESH_DIV*DIGITS + 2; n++) begin
      step(1);
      for (int k = 0; k < DIGITS; k++)
        if (digit_en == (DIGITS'(1) << k)) shown[k*7 +: 7] = seg;
    end
  endtask

  task automatic test_reset();
    logic [COLS-1:0]   exp_col;
    logic [DIGITS-1:0] exp_en;
    step(2);
    tests_run += 5;
    if (col_q !== 4'b1110) begin tests_failed++; $display("[TB] FAIL reset_col_q: got %b expected 1110", col_q); end
    if (digit_en !== 2'b01) begin tests_failed++; $display("[TB] FAIL reset_digit_en: got %b expected 01", digit_en); end
    if (seg !== 7'h7F) begin tests_failed++; $display("[TB] FAIL reset_seg: got %h expected 7f", seg); end
    if (key_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid); end
    if (key_code !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_key_code: got %h expected 0", key_code); end
    nrst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp_col = ~(COLS'(1) << ((k / SCAN_DIV) % COLS));
      exp_en  = DIGITS'(1) << ((k / REFRESH_DIV) % DIGITS);
      tests_run += 3;
      if (col_q !== exp_col) begin tests_failed++; $display("[TB] FAIL idle_col_q cycle %0d: got %b expected %b", k, col_q, exp_col); end
      if (digit_en !== exp_en) begin tests_failed++; $display("[TB] FAIL idle_digit_en cycle %0d: got %b expected %b", k, digit_en, exp_en); end
      if (seg !== 7'h7F) begin tests_failed++; $display("[TB] FAIL idle_seg cycle %0d: got %h expected 7f", k, seg); end
    end
  endtask

  task automatic test_single_key();
    int v0, t0, t_rel, n;
    logic [DIGITS*7-1:0] shown;
    v0 = valid_count;
    t0 = cyc;
    key_down(1, 2);
    step(40);
    tests_run += 5;
    if (col_q !== 4'b1011) begin tests_failed++; $display("[TB] FAIL held_col_q: got %b expected 1011", col_q); end
    if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL single_accepts: got %0d expected 1", valid_count - v0); end
    if (last_valid_code !== 4'h6) begin tests_failed++; $display("[TB] FAIL single_pulse_code: got %h expected 6", last_valid_code); end
    if (last_valid_cyc - t0 < DEB + 2 || last_valid_cyc - t0 > 40) begin
      tests_failed++; $display("[TB] FAIL single_latency: got %0d expected %0d..40", last_valid_cyc - t0, DEB + 2);
    end
    if (key_code !== 4'h6) begin tests_failed++; $display("[TB] FAIL single_key_code: got %h expected 6", key_code); end
    model_accept(1, 2);
    key_up(1, 2);
    t_rel = cyc;
    n = 0;
    while (col_q === 4'b1011 && n < 40) begin step(1); n++; end
    tests_run += 2;
    if (col_q !== 4'b0111) begin tests_failed++; $display("[TB] FAIL resume_col_q: got %b expected 0111", col_q); end
    if (cyc - t_rel < DEB || n >= 40) begin tests_failed++; $display("[TB] FAIL release_time: got %0d cycles expected >= %0d", cyc - t_rel, DEB); end
    sample_display(shown);
    for (int k = 0; k < DIGITS; k++) begin
      tests_run++;
      if (shown[k*7 +: 7] !== exp_slot(k)) begin tests_failed++; $display("[TB] FAIL single_display slot %0d: got %h expected %h", k, shown[k*7 +: 7], exp_slot(k)); end
    end
  endtask

  task automatic test_bounce();
    int v0;
    bit pat [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    v0 = valid_count;
    for (int i = 0; i < 10; i++) begin
      pressed[1][2] = pat[i];
      step(1);
    end
    key_down(1, 2);
    step(DEB);
    tests_run++;
    if (valid_count !== v0) begin tests_failed++; $display("[TB] FAIL bounce_early_accept: got %0d expected 0", valid_count - v0); end
    step(45);
    tests_run += 2;
    if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL bounce_accepts: got %0d expected 1", valid_count - v0); end
    if (last_valid_code !== 4'h6) begin tests_failed++; $display("[TB] FAIL bounce_code: got %h expected 6", last_valid_code); end
    model_accept(1, 2);
    key_up(1, 2);
    step(30);
  endtask

  task automatic test_ghost();
    int v0, changes, bad;
    logic [COLS-1:0] prev;
    v0 = valid_count;
    key_down(0, 0);
    key_down(2, 0);
    prev = col_q;
    changes = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (col_q !== prev) changes++;
      if ($countones(~col_q) != 1) bad++;
      prev = col_q;
    end
    tests_run += 3;
    if (valid_count !== v0) begin tests_failed++; $display("[TB] FAIL ghost_accepts: got %0d expected 0", valid_count - v0); end
    if (changes !== 64 / SCAN_DIV) begin tests_failed++; $display("[TB] FAIL ghost_scan_steps: got %0d expected %0d", changes, 64 / SCAN_DIV); end
    if (bad !== 0) begin tests_failed++; $display("[TB] FAIL ghost_col_onehot: got %0d bad samples expected 0", bad); end
    key_up(0, 0);
    key_up(2, 0);
    step(20);
  endtask

  task automatic test_enter_sequence();
    int v0;
    logic [DIGITS*7-1:0] shown;
    do_reset();
    v0 = valid_count;
    for (int i = 0; i < 3; i++) begin
      key_down(0, i);
      step(40);
      key_up(0, i);
      model_accept(0, i);
      step(24);
    end
    tests_run += 2;
    if (valid_count - v0 !== 3) begin tests_failed++; $display("[TB] FAIL seq_accepts: got %0d expected 3", valid_count - v0); end
    if (key_code !== 4'h3) begin tests_failed++; $display("[TB] FAIL seq_key_code: got %h expected 3", key_code); end
    sample_display(shown);
    for (int k = 0; k < DIGITS; k++) begin
      tests_run++;
      if (shown[k*7 +: 7] !== exp_slot(k)) begin tests_failed++; $display("[TB] FAIL seq_display slot %0d: got %h expected %h", k, shown[k*7 +: 7], exp_slot(k)); end
    end
  endtask

  task automatic test_hold_multi();
    int v0;
    v0 = valid_count;
    key_down(1, 1);
    step(40);
    key_down(2, 2);
    step(20);
    key_up(2, 2);
    step(20);
    tests_run += 2;
    if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL hold_accepts: got %0d expected 1", valid_count - v0); end
    if (last_valid_code !== 4'h5) begin tests_failed++; $display("[TB] FAIL hold_code: got %h expected 5", last_valid_code); end
    model_accept(1, 1);
    key_down(2, 2);
    step(20);
    tests_run++;
    if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL hold_second_blocked: got %0d expected 1", valid_count - v0); end
    key_up(1, 1);
    step(60);
    tests_run += 2;
    if (valid_count - v0 !== 2) begin tests_failed++; $display("[TB] FAIL hold_after_release: got %0d expected 2", valid_count - v0); end
    if (last_valid_code !== 4'h9) begin tests_failed++; $display("[TB] FAIL hold_after_code: got %h expected 9", last_valid_code); end
    model_accept(2, 2);
    key_up(2, 2);
    step(30);
  endtask

  task automatic test_reset_mid_press();
    int v0, n;
    logic [DIGITS*7-1:0] shown;
    do_reset();
    v0 = valid_count;
    key_down(0, 0);
    step(8);
    nrst = 1'b0;
    #1;
    tests_run += 2;
    if (col_q !== 4'b1110) begin tests_failed++; $display("[TB] FAIL midreset_col_q: got %b expected 1110", col_q); end
    if (valid_count !== v0) begin tests_failed++; $display("[TB] FAIL midreset_accepts: got %0d expected 0", valid_count - v0); end
    step(3);
    nrst = 1'b1;
    step(DEB + 2);
    tests_run++;
    if (valid_count !== v0) begin tests_failed++; $display("[TB] FAIL midreset_early_accept: got %0d expected 0", valid_count - v0); end
    n = 0;
    while (valid_count == v0 && n < 40) begin step(1); n++; end
    tests_run += 2;
    if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL midreset_timeout: got %0d accepts expected 1", valid_count - v0); end
    if (last_valid_code !== 4'h1) begin tests_failed++; $display("[TB] FAIL midreset_code: got %h expected 1", last_valid_code); end
    model_accept(0, 0);
    key_up(0, 0);
    step(30);
    sample_display(shown);
    for (int k = 0; k < DIGITS; k++) begin
      tests_run++;
      if (shown[k*7 +: 7] !== exp_slot(k)) begin tests_failed++; $display("[TB] FAIL midreset_display slot %0d: got %h expected %h", k, shown[k*7 +: 7], exp_slot(k)); end
    end
  endtask

  task automatic test_random_entry();
    int v0, idx, r, c;
    logic [DIGITS*7-1:0] shown;
    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, ROWS*COLS - 1));
      r = idx / COLS;
      c = idx % COLS;
      v0 = valid_count;
      key_down(r, c);
      step(40 + int'($urandom_range(0, 15)));
      key_up(r, c);
      step(24 + int'($urandom_range(0, 10)));
      model_accept(r, c);
      tests_run += 2;
      if (valid_count - v0 !== 1) begin tests_failed++; $display("[TB] FAIL rand_accepts key %0d: got %0d expected 1", idx, valid_count - v0); end
      if (last_valid_code !== label[idx]) begin tests_failed++; $display("[TB] FAIL rand_code key %0d: got %h expected %h", idx, last_valid_code, label[idx]); end
    end
    sample_display(shown);
    for (int k = 0; k < DIGITS; k++) begin
      tests_run++;
      if (shown[k*7 +: 7] !== exp_slot(k)) begin tests_failed++; $display("[TB] FAIL rand_display slot %0d: got %h expected %h", k, shown[k*7 +: 7], exp_slot(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_ghost();
    test_enter_sequence();
    test_hold_multi();
    test_reset_mid_press();
    test_random_entry();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
